// File: rtl/pio_pkg.sv
// Shared constants and types for the PIO clock-divider block.
//   NUM_SM         number of state-machine divider channels
//   DIV_W          divisor width (16 integer + 8 fractional bits)
//   DIV_FRAC_W     fractional bits of the divisor
//   DIV_ONE        divisor value 1.0, also the per-cycle accumulator step
//   DIV_FAST_LIMIT divisors below this (2.0) strobe every enabled cycle
package pio_pkg;

    localparam int unsigned NUM_SM     = 4;
    localparam int unsigned DIV_W      = 24;
    localparam int unsigned DIV_FRAC_W = 8;

    typedef logic [DIV_W-1:0] div_t;

    localparam div_t DIV_ONE        = 24'h000100;
    localparam div_t DIV_FAST_LIMIT = 24'h000200;

endpackage

// File: rtl/pio_clkdiv_chan.sv
// One 16.8 fractional divider channel producing a registered penable strobe.
//   clk, reset_n  clock and synchronous active-low reset
//   en            channel enable (counts while high)
//   clear         restart: zero the phase, cancel strobe, apply staged divisor
//   load          divisor write for this channel
//   load_div      divisor value for load
//   penable       registered step strobe
//   pending       a written divisor is staged and waits for the next wrap
module pio_clkdiv_chan
    import pio_pkg::*;
#(
    parameter div_t RESET_DIV = DIV_ONE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clear,
    input  logic load,
    input  div_t load_div,
    output logic penable,
    output logic pending
);

    localparam int unsigned SUM_W = DIV_W + 1;

    div_t             acc;
    div_t             active_div;
    div_t             staged_div;
    logic [SUM_W-1:0] sum_c;
    logic             fast_c;
    logic             wrap_c;

    // Wrap detection; fast mode wraps on every enabled cycle.
    always_comb begin
        fast_c = (active_div < DIV_FAST_LIMIT);
        sum_c  = SUM_W'(acc) + SUM_W'(DIV_ONE);
        wrap_c = en && (fast_c || (sum_c >= SUM_W'(active_div)));
    end

    // Accumulator, divisor staging and strobe register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc        <= '0;
            active_div <= RESET_DIV;
            staged_div <= RESET_DIV;
            pending    <= 1'b0;
            penable    <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            penable <= 1'b0;
            pending <= 1'b0;
            // A same-cycle write beats the staged value.
            if (load) begin
                active_div <= load_div;
            end else if (pending) begin
                active_div <= staged_div;
            end
        end else begin
            penable <= wrap_c;
            if (en) begin
                if (fast_c) begin
                    acc <= '0;
                end else if (wrap_c) begin
                    acc <= DIV_W'(sum_c - SUM_W'(active_div));
                end else begin
                    acc <= DIV_W'(sum_c);
                end
            end
            // Staged divisor switches in only at a strobe boundary.
            if (wrap_c && pending) begin
                active_div <= staged_div;
                pending    <= 1'b0;
            end
            // A write this cycle stages for the following wrap (last write wins).
            if (load) begin
                if (en) begin
                    staged_div <= load_div;
                    pending    <= 1'b1;
                end else begin
                    active_div <= load_div;
                    pending    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pio_clkdiv_ctrl.sv
// Clock-divider controller: host write decode, enable mask, NUM_SM channels.
//   clk, reset_n  clock and synchronous active-low reset
//   div_wr        divisor write strobe, div_sel selects channel, div_data value
//   en_wr         enable-mask write strobe, en_data new mask (applied at once)
//   restart       per-channel phase restart strobes
//   penable       registered per-channel step strobes
//   div_pending   per-channel staged-divisor flags
//   en_state      current enable mask
module pio_clkdiv_ctrl #(
    parameter int unsigned      NUM_SM    = 4,
    parameter int unsigned      DIV_W     = 24,
    parameter logic [DIV_W-1:0] RESET_DIV = 24'h000100
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      div_wr,
    input  logic [$clog2(NUM_SM)-1:0] div_sel,
    input  logic [DIV_W-1:0]          div_data,
    input  logic                      en_wr,
    input  logic [NUM_SM-1:0]         en_data,
    input  logic [NUM_SM-1:0]         restart,
    output logic [NUM_SM-1:0]         penable,
    output logic [NUM_SM-1:0]         div_pending,
    output logic [NUM_SM-1:0]         en_state
);

    import pio_pkg::*;

    localparam int unsigned SEL_W = $clog2(NUM_SM);

    logic [NUM_SM-1:0] load_c;

    // Enable mask: every bit changes on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            en_state <= '0;
        end else if (en_wr) begin
            en_state <= en_data;
        end
    end

    for (genvar i = 0; i < NUM_SM; i++) begin : g_chan
        assign load_c[i] = div_wr && (div_sel == SEL_W'(i));

        pio_clkdiv_chan #(
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en_state[i]),
            .clear    (restart[i]),
            .load     (load_c[i]),
            .load_div (div_data),
            .penable  (penable[i]),
            .pending  (div_pending[i])
        );
    end

endmodule

// File: tb/tb_pio_clkdiv_ctrl.sv
// Self-checking bench for pio_clkdiv_ctrl: directed scenarios plus random traffic
// checked every cycle against a closed-form strobe-count model.
module tb_pio_clkdiv_ctrl;

    localparam int NSM = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        div_wr;
    logic [1:0]  div_sel;
    logic [23:0] div_data;
    logic        en_wr;
    logic [3:0]  en_data;
    logic [3:0]  restart;
    logic [3:0]  penable;
    logic [3:0]  div_pending;
    logic [3:0]  en_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: strobes since the last phase reference are floor((r0 + n*256)/d).
    longint m_d[NSM];
    longint m_st[NSM];
    longint m_r0[NSM];
    longint m_n[NSM];
    bit     m_pend[NSM];
    bit     m_pen[NSM];
    bit     m_en[NSM];

    always #5 clk = ~clk;

    pio_clkdiv_ctrl #(.NUM_SM(4), .DIV_W(24), .RESET_DIV(24'h000100)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .div_wr      (div_wr),
        .div_sel     (div_sel),
        .div_data    (div_data),
        .en_wr       (en_wr),
        .en_data     (en_data),
        .restart     (restart),
        .penable     (penable),
        .div_pending (div_pending),
        .en_state    (en_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint residual(input int i);
        if (m_d[i] < 512) return 0;
        return (m_r0[i] + m_n[i] * 256) % m_d[i];
    endfunction

    task automatic chan_step(input int i, input bit clr, input bit ld, input longint ldv);
        longint tot;
        bit     wrap;
        if (clr) begin
            m_n[i] = 0; m_r0[i] = 0; m_pen[i] = 0;
            if (ld) begin
                m_d[i] = ldv; m_pend[i] = 0;
            end else if (m_pend[i]) begin
                m_d[i] = m_st[i]; m_pend[i] = 0;
            end
            return;
        end
        wrap = 0;
        if (m_en[i]) begin
            if (m_d[i] < 512) begin
                wrap = 1; m_n[i] = 0; m_r0[i] = 0;
            end else begin
                tot = m_r0[i] + m_n[i] * 256;
                m_n[i]++;
                wrap = ((tot + 256) / m_d[i]) > (tot / m_d[i]);
            end
        end
        m_pen[i] = wrap;
        if (wrap && m_pend[i]) begin
            m_r0[i] = residual(i); m_n[i] = 0;
            m_d[i] = m_st[i]; m_pend[i] = 0;
        end
        if (ld) begin
            if (m_en[i]) begin
                m_st[i] = ldv; m_pend[i] = 1;
            end else begin
                m_r0[i] = residual(i); m_n[i] = 0;
                m_d[i] = ldv; m_pend[i] = 0;
            end
        end
    endtask

    // One clock: advance model with the inputs sampled at the edge, compare, drop strobes.
    task automatic tick();
        logic [3:0] e_pen, e_dp, e_en;
        bit ld;
        @(posedge clk);
        for (int i = 0; i < NSM; i++) begin
            if (!reset_n) begin
                m_d[i] = 256; m_st[i] = 256; m_r0[i] = 0; m_n[i] = 0;
                m_pend[i] = 0; m_pen[i] = 0; m_en[i] = 0;
            end else begin
                ld = div_wr && (div_sel == 2'(i));
                chan_step(i, restart[i], ld, longint'(div_data));
                if (en_wr) m_en[i] = en_data[i];
            end
        end
        #1;
        for (int i = 0; i < NSM; i++) begin
            e_pen[i] = m_pen[i]; e_dp[i] = m_pend[i]; e_en[i] = m_en[i];
        end
        check("model_penable", 32'(penable), 32'(e_pen));
        check("model_div_pending", 32'(div_pending), 32'(e_dp));
        check("model_en_state", 32'(en_state), 32'(e_en));
        div_wr = 1'b0; en_wr = 1'b0; restart = '0;
    endtask

    initial begin
        logic [15:0] pat0, pat1;
        int cnt, last, idx, t;
        bit ok;

        reset_n = 1'b0; div_wr = 1'b0; div_sel = '0; div_data = '0;
        en_wr = 1'b0; en_data = '0; restart = '0;

        // Reset state
        tick(); tick();
        check("rst_penable", 32'(penable), 0);
        check("rst_div_pending", 32'(div_pending), 0);
        check("rst_en_state", 32'(en_state), 0);
        reset_n = 1'b1;

        // ch0 = 0x300 while disabled, then enable: strobes on enabled cycles 3,6,9
        div_wr = 1'b1; div_sel = 2'd0; div_data = 24'h300; tick();
        check("disabled_write_no_pending", 32'(div_pending), 0);
        en_wr = 1'b1; en_data = 4'b0001; tick();
        check("en_state_0001", 32'(en_state), 32'h1);
        pat0 = '0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            pat0[k-1] = penable[0];
            check("others_quiet", 32'(penable[3:1]), 0);
        end
        check("ch0_0x300_pattern", 32'(pat0), 32'h124);

        // ch1 = 0x280: gaps 2,3,2,3 and 256 strobes in 640 enabled cycles
        div_wr = 1'b1; div_sel = 2'd1; div_data = 24'h280; tick();
        en_wr = 1'b1; en_data = 4'b0011; tick();
        cnt = 0; last = 0; idx = 0; ok = 1;
        for (int k = 1; k <= 640; k++) begin
            tick();
            if (penable[1]) begin
                if (idx == 0) ok &= (k == 3);
                else ok &= ((k - last) == (2 + ((idx - 1) % 2)));
                last = k; idx++; cnt++;
            end
        end
        check("ch1_0x280_count", 32'(cnt), 256);
        check("ch1_0x280_gaps", 32'(ok), 1);

        // ch2 = 1.0, ch3 = 0: fast mode follows enable with one cycle of latency
        div_wr = 1'b1; div_sel = 2'd2; div_data = 24'h100; tick();
        div_wr = 1'b1; div_sel = 2'd3; div_data = 24'h000; tick();
        en_wr = 1'b1; en_data = 4'b1111; tick();
        check("fast_not_yet", 32'(penable[3:2]), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fast_held_high", 32'(penable[3:2]), 32'h3);
        end
        en_wr = 1'b1; en_data = 4'b0011; tick();
        check("fast_still_high", 32'(penable[3:2]), 32'h3);
        tick();
        check("fast_fall", 32'(penable[3:2]), 0);

        // ch0 restart at 0x400, write 0x200 mid-period: staged until the strobe
        restart = 4'b0001; div_wr = 1'b1; div_sel = 2'd0; div_data = 24'h400; tick();
        tick(); tick();
        div_wr = 1'b1; div_sel = 2'd0; div_data = 24'h200; tick();
        check("staged_pending", 32'(div_pending[0]), 1);
        check("staged_no_strobe", 32'(penable[0]), 0);
        tick();
        check("wrap_strobe", 32'(penable[0]), 1);
        check("wrap_applies", 32'(div_pending[0]), 0);
        pat0 = '0;
        for (int k = 5; k <= 12; k++) begin
            tick();
            pat0[k-5] = penable[0];
        end
        check("new_div_gap2", 32'(pat0), 32'hAA);

        // Out-of-phase ch0 (0x300) / ch1 (staged 0x500), joint restart aligns them
        div_wr = 1'b1; div_sel = 2'd1; div_data = 24'h500; tick();
        check("ch1_pending", 32'(div_pending[1]), 1);
        restart = 4'b0011; div_wr = 1'b1; div_sel = 2'd0; div_data = 24'h300; tick();
        check("restart_cancels", 32'(penable[1:0]), 0);
        check("restart_applies", 32'(div_pending[1:0]), 0);
        pat0 = '0; pat1 = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            pat0[k-1] = penable[0];
            pat1[k-1] = penable[1];
        end
        check("aligned_ch0", 32'(pat0), 32'h124);
        check("aligned_ch1", 32'(pat1), 32'h210);

        // Reset during a pending write and running strobes
        div_wr = 1'b1; div_sel = 2'd0; div_data = 24'h800; tick();
        check("pre_reset_pending", 32'(div_pending[0]), 1);
        reset_n = 1'b0; tick();
        check("mid_rst_penable", 32'(penable), 0);
        check("mid_rst_div_pending", 32'(div_pending), 0);
        check("mid_rst_en_state", 32'(en_state), 0);
        reset_n = 1'b1;
        en_wr = 1'b1; en_data = 4'b0001; tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("reset_div_is_one", 32'(penable), 32'h1);
        end

        // Random traffic; a write to a disabled channel is paired with its restart
        for (int it = 0; it < 1500; it++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) begin
                div_wr = 1'b1;
                div_sel = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 9))
                    0: div_data = 24'h000;
                    1: div_data = 24'h100;
                    2: div_data = 24'h1FF;
                    3: div_data = 24'h200;
                    4: div_data = 24'h280;
                    5: div_data = 24'h300;
                    6: div_data = 24'h3C0;
                    7: div_data = 24'h555;
                    8: div_data = 24'h1000;
                    default: div_data = 24'($urandom_range(512, 4095));
                endcase
            end
            for (int i = 0; i < NSM; i++) restart[i] = ($urandom_range(0, 15) == 0);
            if (div_wr && !m_en[div_sel]) restart[div_sel] = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                en_wr = 1'b1;
                en_data = 4'($urandom);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
